csa_accum_ctrl: RTL and testbench



---
 rtl/csa_accum_ctrl.sv | 115 +++++++++++
 tb/tb_csa_accum_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/csa_accum_ctrl.sv
// rtl/csa_accum_ctrl.sv - carry-save multi-operand accumulator sequencer (optional CSA_CYC_CNT_EN adds cyc_cnt)
module csa_accum_ctrl #(
    parameter int W     = 4,
    parameter int MAXN  = 8,
    parameter int CNT_W = 4,
    parameter int ACC_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_ops,
    output logic             busy,
    input  logic             op_valid,
    input  logic [W-1:0]     op_data,
    output logic             op_ready,
    output logic [ACC_W-1:0] result,
    output logic             res_valid,
    input  logic             res_ready
`ifdef CSA_CYC_CNT_EN
    ,
    output logic [7:0]       cyc_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    state_t           state;
    logic [ACC_W-1:0] sum_r;
    logic [ACC_W-1:0] carry_r;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] n_clamp;
    logic [CNT_W-1:0] cnt_inc;
    logic [ACC_W-1:0] x;
    logic [ACC_W-1:0] sum_nx;
    logic [ACC_W-1:0] carry_nx;
    logic             take;

    assign x        = ACC_W'(op_data);
    assign n_clamp  = (n_ops > CNT_W'(MAXN)) ? CNT_W'(MAXN) : n_ops;
    assign cnt_inc  = cnt + 1'b1;
    assign take     = (state == ACCUM) && op_valid;

    // 3:2 compressor row: carries leaving the top bit are dropped, which is
    // harmless because the result is only defined modulo 2^ACC_W
    assign sum_nx   = sum_r ^ carry_r ^ x;
    assign carry_nx = ((sum_r & carry_r) | (sum_r & x) | (carry_r & x)) << 1;

    assign op_ready  = (state == ACCUM);
    assign busy      = (state != IDLE);
    assign res_valid = (state == DONE);

    // Job sequencing: latch job size, compress operands, resolve, hold result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sum_r   <= '0;
            carry_r <= '0;
            cnt     <= '0;
            target  <= '0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        target  <= n_clamp;
                        sum_r   <= '0;
                        carry_r <= '0;
                        cnt     <= '0;
                        if (n_clamp == '0) begin
                            result <= '0;
                            state  <= DONE;
                        end else begin
                            state  <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (take) begin
                        sum_r   <= sum_nx;
                        carry_r <= carry_nx;
                        cnt     <= cnt_inc;
                        if (cnt_inc == target) begin
                            state <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    result <= sum_r + carry_r;
                    state  <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CSA_CYC_CNT_EN
    // Job cycle counter: cleared on start, counts ACCUM/RESOLVE cycles, saturates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt <= '0;
        end else if (state == IDLE && start) begin
            cyc_cnt <= '0;
        end else if ((state == ACCUM || state == RESOLVE) && cyc_cnt != 8'hFF) begin
            cyc_cnt <= cyc_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// tb/tb_csa_accum_ctrl.sv - scoreboard bench for csa_accum_ctrl
module tb_csa_accum_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] n_ops = '0;
    logic       busy;
    logic       op_valid = 1'b0;
    logic [3:0] op_data = '0;
    logic       op_ready;
    logic [6:0] result;
    logic       res_valid;
    logic       res_ready = 1'b0;
`ifdef CSA_CYC_CNT_EN
    logic [7:0] cyc_cnt;
`endif

    int         errors = 0;
    int         checks = 0;
    int         accepts = 0;
    logic [6:0] sbq[$];
    logic [3:0] opv [0:15];

    csa_accum_ctrl #(.W(4), .MAXN(8), .CNT_W(4), .ACC_W(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_ops     (n_ops),
        .busy      (busy),
        .op_valid  (op_valid),
        .op_data   (op_data),
        .op_ready  (op_ready),
        .result    (result),
        .res_valid (res_valid),
        .res_ready (res_ready)
`ifdef CSA_CYC_CNT_EN
        ,
        .cyc_cnt   (cyc_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: counts operand handshakes and scores every result handshake
    initial begin
        logic [6:0] e;
        forever begin
            @(negedge clk);
            if (op_valid && op_ready) accepts++;
            if (res_valid && res_ready) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_result", 32'(result), 32'hFFFF);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_result", 32'(result), 32'(e));
                end
            end
        end
    end

    task automatic run_job(input int n, input int nfeed, input logic [6:0] exp,
                           input bit toggle, input bit hold, input bit extra);
        int   i;
        int   cyc;
        int   lat;
        logic tk;
        sbq.push_back(exp);
        accepts = 0;
        @(posedge clk); #1;
        start = 1'b1;
        n_ops = 4'(n);
        @(posedge clk); #1;
        start = 1'b0;
        i = 0;
        cyc = 0;
        while (i < nfeed && cyc < 200) begin
            op_valid = toggle ? ~cyc[0] : 1'b1;
            op_data  = opv[i];
            @(negedge clk);
            tk = op_valid && op_ready;
            chk("busy_in_accum", 32'(busy), 32'd1);
            @(posedge clk); #1;
            if (tk) i++;
            cyc++;
        end
        chk("ops_fed", 32'(i), 32'(nfeed));
        op_valid  = extra;
        op_data   = 4'h9;
        res_ready = !hold;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            chk("busy_wait", 32'(busy), 32'd1);
            chk("op_ready_outside_accum", 32'(op_ready), 32'd0);
            if (res_valid || lat >= 50) break;
        end
        chk("res_latency", 32'(lat), (nfeed == 0) ? 32'd1 : 32'd2);
        if (hold) begin
            repeat (5) begin
                @(posedge clk); #1;
                start = 1'b1;
                n_ops = 4'd1;
                @(negedge clk);
                chk("hold_valid", 32'(res_valid), 32'd1);
                chk("hold_result", 32'(result), 32'(exp));
            end
            @(posedge clk); #1;
            res_ready = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end else begin
            @(posedge clk); #1;
        end
        res_ready = 1'b0;
        op_valid  = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_res_valid", 32'(res_valid), 32'd0);
        chk("accepts", 32'(accepts), 32'(nfeed));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_ready", 32'(op_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // three 4'hF back-to-back: 45
        for (int k = 0; k < 3; k++) opv[k] = 4'hF;
        run_job(3, 3, 7'd45, 1'b0, 1'b0, 1'b0);
`ifdef CSA_CYC_CNT_EN
        chk("cyc_cnt", 32'(cyc_cnt), 32'd4);
`endif

        // eight 4'hF with toggling valid: 120
        for (int k = 0; k < 8; k++) opv[k] = 4'hF;
        run_job(8, 8, 7'd120, 1'b1, 1'b0, 1'b0);

        // empty job goes straight to DONE
        run_job(0, 0, 7'd0, 1'b0, 1'b0, 1'b0);

        // n_ops=12 clamps to 8: 1+..+8 = 36, extra valid never taken
        for (int k = 0; k < 8; k++) opv[k] = 4'(k + 1);
        run_job(12, 8, 7'd36, 1'b0, 1'b0, 1'b1);

        // backpressure with ignored starts: 7+9 = 16
        opv[0] = 4'd7;
        opv[1] = 4'd9;
        run_job(2, 2, 7'd16, 1'b0, 1'b1, 1'b0);

        // abort mid-job after 2 of 4 operands
        @(posedge clk); #1;
        start = 1'b1;
        n_ops = 4'd4;
        @(posedge clk); #1;
        start    = 1'b0;
        op_valid = 1'b1;
        op_data  = 4'd6;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_op_ready", 32'(op_ready), 32'd0);
        chk("abort_res_valid", 32'(res_valid), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        op_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // job after abort: 3+5 = 8
        opv[0] = 4'd3;
        opv[1] = 4'd5;
        run_job(2, 2, 7'd8, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
